// File: rtl/wb_multi_master_if.sv
// Wishbone B3 classic bus bundle shared by the multi-port master and its slave.
// The master modport drives the request side; the slave modport answers it.
interface wb_multi_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_we_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/wb_multi_master.sv
// Multi-port Wishbone B3 classic master. Each port posts a one-cycle start
// pulse; the request is latched per port, arbitrated round-robin, and issued
// as a single-transfer bus cycle with optional ack/err timeout.
module wb_multi_master #(
    parameter int NUM_PORTS = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                      wb_clk,
    input  logic                      wb_rst_n,
    input  logic [NUM_PORTS-1:0]      port_start,
    input  logic [NUM_PORTS*AW-1:0]   port_address,
    input  logic [NUM_PORTS*DW/8-1:0] port_selection,
    input  logic [NUM_PORTS-1:0]      port_write,
    input  logic [NUM_PORTS*DW-1:0]   port_data_wr,
    output logic [NUM_PORTS-1:0]      port_active,
    output logic [NUM_PORTS-1:0]      port_done,
    output logic [NUM_PORTS-1:0]      port_err,
    output logic [NUM_PORTS*DW-1:0]   port_data_rd,
    wb_multi_master_if.master         wb
);

    localparam int SW = DW / 8;
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_DONE
    } state_t;

    state_t                r_state;
    logic [NUM_PORTS-1:0]  r_active;
    logic [NUM_PORTS-1:0]  r_done;
    logic [NUM_PORTS-1:0]  r_err;
    logic [NUM_PORTS*DW-1:0] r_data_rd;
    logic [PW-1:0]         r_rr_ptr;
    logic [PW-1:0]         r_winner;
    logic [CW-1:0]         r_cnt;

    // Latched per-port request fields.
    logic [AW-1:0]         r_req_adr [NUM_PORTS];
    logic [DW-1:0]         r_req_dat [NUM_PORTS];
    logic [SW-1:0]         r_req_sel [NUM_PORTS];
    logic [NUM_PORTS-1:0]  r_req_we;

    // Registered bus outputs; stb always mirrors cyc for single transfers.
    logic [AW-1:0]         r_wb_adr;
    logic [DW-1:0]         r_wb_dat;
    logic [SW-1:0]         r_wb_sel;
    logic                  r_wb_we;
    logic                  r_wb_cyc;

    logic [NUM_PORTS-1:0]  w_accept;
    logic                  w_pick_found;
    logic [PW-1:0]         w_pick_idx;
    logic [PW-1:0]         w_next_ptr;

    // Wrap (ptr + off) into the port range.
    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] ptr, input int off);
        int idx;
        idx = int'(ptr) + off;
        if (idx >= NUM_PORTS) idx -= NUM_PORTS;
        return PW'(idx);
    endfunction

    // A start is taken only from a port that has nothing outstanding.
    assign w_accept = port_start & ~r_active;

    // Round-robin search over pending ports starting at the RR pointer.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        // Walk from the farthest offset down so the nearest pending port wins.
        for (int off = NUM_PORTS - 1; off >= 0; off--) begin
            if (r_active[rr_index(r_rr_ptr, off)]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = rr_index(r_rr_ptr, off);
            end
        end
        w_next_ptr = (w_pick_idx == LAST_PORT) ? '0 : w_pick_idx + 1'b1;
    end

    // Capture each port's request fields when its start is accepted.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            // NOTE: these are a handful of flops rather than a RAM, so they
            // take the reset and a grant can never put X on the bus.
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_req_adr[i] <= '0;
                r_req_dat[i] <= '0;
                r_req_sel[i] <= '0;
            end
            r_req_we <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_accept[i]) begin
                    r_req_adr[i] <= port_address[i*AW +: AW];
                    r_req_dat[i] <= port_data_wr[i*DW +: DW];
                    r_req_sel[i] <= port_selection[i*SW +: SW];
                    r_req_we[i]  <= port_write[i];
                end
            end
        end
    end

    // Control FSM: grant in IDLE, hold the cycle in BUS, pulse done in DONE.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state   <= ST_IDLE;
            r_active  <= '0;
            r_done    <= '0;
            r_err     <= '0;
            r_data_rd <= '0;
            r_rr_ptr  <= '0;
            r_winner  <= '0;
            r_cnt     <= '0;
            r_wb_adr  <= '0;
            r_wb_dat  <= '0;
            r_wb_sel  <= '0;
            r_wb_we   <= 1'b0;
            r_wb_cyc  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // reads the pre-edge r_active/r_winner and later writes override
            // earlier defaults without ordering hazards.
            r_active <= r_active | w_accept;
            r_done   <= '0;
            r_err    <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_found) begin
                        r_winner <= w_pick_idx;
                        r_rr_ptr <= w_next_ptr;
                        r_wb_adr <= r_req_adr[w_pick_idx];
                        r_wb_dat <= r_req_dat[w_pick_idx];
                        r_wb_sel <= r_req_sel[w_pick_idx];
                        r_wb_we  <= r_req_we[w_pick_idx];
                        r_wb_cyc <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (wb.wb_err_i) begin
                        // Error wins over a simultaneous ack; read data is kept.
                        r_wb_cyc           <= 1'b0;
                        r_wb_we            <= 1'b0;
                        r_done[r_winner]   <= 1'b1;
                        r_err[r_winner]    <= 1'b1;
                        r_state            <= ST_DONE;
                    end else if (wb.wb_ack_i) begin
                        if (!r_wb_we) begin
                            r_data_rd[r_winner*DW +: DW] <= wb.wb_dat_i;
                        end
                        r_wb_cyc           <= 1'b0;
                        r_wb_we            <= 1'b0;
                        r_done[r_winner]   <= 1'b1;
                        r_state            <= ST_DONE;
                    end else if (TIMEOUT != 0 && r_cnt == TO_LAST) begin
                        r_wb_cyc           <= 1'b0;
                        r_wb_we            <= 1'b0;
                        r_done[r_winner]   <= 1'b1;
                        r_err[r_winner]    <= 1'b1;
                        r_state            <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The winner was active, so it cannot be re-accepted here.
                    r_active[r_winner] <= 1'b0;
                    r_state            <= ST_IDLE;
                end
                default: begin
                    r_wb_cyc <= 1'b0;
                    r_wb_we  <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign port_active  = r_active;
    assign port_done    = r_done;
    assign port_err     = r_err;
    assign port_data_rd = r_data_rd;

    assign wb.wb_adr_o = r_wb_adr;
    assign wb.wb_dat_o = r_wb_dat;
    assign wb.wb_sel_o = r_wb_sel;
    assign wb.wb_we_o  = r_wb_we;
    assign wb.wb_cyc_o = r_wb_cyc;
    assign wb.wb_stb_o = r_wb_cyc;

endmodule

// File: tb/tb_wb_multi_master.sv
// Directed bench for wb_multi_master: a vector table of single transfers
// plus hand-written sequences for arbitration, ignored starts and reset.
module tb_wb_multi_master;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    typedef enum logic [1:0] {R_ACK, R_ERR, R_BOTH, R_NONE} resp_t;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          waits;
        resp_t       resp;
        logic [31:0] rdata;
        logic        exp_err;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
    } vec_t;

    logic                wb_clk = 1'b0;
    logic                wb_rst_n = 1'b0;
    logic [NP-1:0]       port_start = '0;
    logic [NP*AW-1:0]    port_address = '0;
    logic [NP*SW-1:0]    port_selection = '0;
    logic [NP-1:0]       port_write = '0;
    logic [NP*DW-1:0]    port_data_wr = '0;
    logic [NP-1:0]       port_active;
    logic [NP-1:0]       port_done;
    logic [NP-1:0]       port_err;
    logic [NP*DW-1:0]    port_data_rd;

    int n_chk = 0;
    int n_err = 0;

    wb_multi_master_if #(.AW(AW), .DW(DW)) bus ();

    wb_multi_master #(
        .NUM_PORTS(NP), .AW(AW), .DW(DW), .TIMEOUT(TO)
    ) dut (
        .wb_clk         (wb_clk),
        .wb_rst_n       (wb_rst_n),
        .port_start     (port_start),
        .port_address   (port_address),
        .port_selection (port_selection),
        .port_write     (port_write),
        .port_data_wr   (port_data_wr),
        .port_active    (port_active),
        .port_done      (port_done),
        .port_err       (port_err),
        .port_data_rd   (port_data_rd),
        .wb             (bus)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int p, input logic we, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel);
        port_write[p]               = we;
        port_address[p*AW +: AW]    = adr;
        port_data_wr[p*DW +: DW]    = dat;
        port_selection[p*SW +: SW]  = sel;
    endtask

    // Issue one transfer from idle, answer it as the vector says, check all.
    task automatic run_vec(input vec_t v, input int id);
        int    lat;
        int    ncyc;
        string tag;
        tag = $sformatf("v%0d", id);
        drive_req(v.port, v.we, v.adr, v.dat, v.sel);
        port_start = '0;
        port_start[v.port] = 1'b1;
        lat = 0;
        do begin
            @(negedge wb_clk);
            port_start = '0;
            lat++;
        end while (!bus.wb_cyc_o && lat < 8);
        check({tag, " latency"}, 64'(lat), 64'd2);
        check({tag, " stb"}, 64'(bus.wb_stb_o), 64'd1);
        check({tag, " adr"}, 64'(bus.wb_adr_o), 64'(v.adr));
        check({tag, " we"}, 64'(bus.wb_we_o), 64'(v.we));
        check({tag, " sel"}, 64'(bus.wb_sel_o), 64'(v.sel));
        if (v.we) check({tag, " dat_o"}, 64'(bus.wb_dat_o), 64'(v.dat));
        if (v.resp == R_NONE) begin
            ncyc = 1;
            while (ncyc < 20) begin
                @(negedge wb_clk);
                if (!bus.wb_cyc_o) break;
                ncyc++;
            end
            check({tag, " timeout cycles"}, 64'(ncyc), 64'(TO));
        end else begin
            repeat (v.waits) @(negedge wb_clk);
            check({tag, " cyc held"}, 64'(bus.wb_cyc_o), 64'd1);
            bus.wb_ack_i = (v.resp == R_ACK) || (v.resp == R_BOTH);
            bus.wb_err_i = (v.resp == R_ERR) || (v.resp == R_BOTH);
            bus.wb_dat_i = v.rdata;
            @(negedge wb_clk);
            bus.wb_ack_i = 1'b0;
            bus.wb_err_i = 1'b0;
            check({tag, " cyc dropped"}, 64'(bus.wb_cyc_o), 64'd0);
        end
        check({tag, " done"}, 64'(port_done), 64'(2'b01 << v.port));
        check({tag, " err"}, 64'(port_err), 64'(v.exp_err ? (2'b01 << v.port) : 2'b00));
        check({tag, " rd0"}, 64'(port_data_rd[0 +: DW]), 64'(v.exp_rd0));
        check({tag, " rd1"}, 64'(port_data_rd[DW +: DW]), 64'(v.exp_rd1));
        @(negedge wb_clk);
        check({tag, " done cleared"}, 64'(port_done), 64'd0);
        check({tag, " active cleared"}, 64'(port_active), 64'd0);
    endtask

    // Wait (bounded) for a cycle, ack it with rdata and return its address.
    task automatic serve(input logic [31:0] rdata, output logic [31:0] adr);
        int n;
        n = 0;
        while (!bus.wb_cyc_o && n < 8) begin
            @(negedge wb_clk);
            n++;
        end
        check("serve cyc seen", 64'(bus.wb_cyc_o), 64'd1);
        adr = bus.wb_adr_o;
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = rdata;
        @(negedge wb_clk);
        bus.wb_ack_i = 1'b0;
        @(negedge wb_clk);
    endtask

    task automatic apply_reset();
        wb_rst_n = 1'b0;
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b1;
    endtask

    vec_t        vecs [6];
    vec_t        v_after_rst;
    logic [31:0] got_adr;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1, R_ACK,  32'hBAD0_BAD0, 1'b0, 32'h0,         32'h0};
        vecs[1] = '{0, 1'b0, 32'h0000_0020, 32'h0,         4'hF, 0, R_ACK,  32'h1234_5678, 1'b0, 32'h1234_5678, 32'h0};
        vecs[2] = '{1, 1'b0, 32'h0000_0040, 32'h0,         4'h3, 2, R_ACK,  32'hCAFE_F00D, 1'b0, 32'h1234_5678, 32'hCAFE_F00D};
        vecs[3] = '{0, 1'b1, 32'h0000_0044, 32'h55AA_55AA, 4'hC, 0, R_ERR,  32'h0,         1'b1, 32'h1234_5678, 32'hCAFE_F00D};
        vecs[4] = '{1, 1'b0, 32'h0000_0048, 32'h0,         4'hF, 0, R_BOTH, 32'hFFFF_0000, 1'b1, 32'h1234_5678, 32'hCAFE_F00D};
        vecs[5] = '{0, 1'b0, 32'h0000_004C, 32'h0,         4'hF, 0, R_NONE, 32'h0,         1'b1, 32'h1234_5678, 32'hCAFE_F00D};
        v_after_rst = '{0, 1'b0, 32'h0000_0064, 32'h0, 4'hF, 0, R_ACK, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE, 32'h0};

        bus.wb_dat_i = '0;
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;

        // Reset values while reset is held.
        @(negedge wb_clk);
        check("rst cyc", 64'(bus.wb_cyc_o), 64'd0);
        check("rst stb", 64'(bus.wb_stb_o), 64'd0);
        check("rst we", 64'(bus.wb_we_o), 64'd0);
        check("rst adr", 64'(bus.wb_adr_o), 64'd0);
        check("rst dat_o", 64'(bus.wb_dat_o), 64'd0);
        check("rst sel", 64'(bus.wb_sel_o), 64'd0);
        check("rst active", 64'(port_active), 64'd0);
        check("rst done", 64'(port_done), 64'd0);
        check("rst err", 64'(port_err), 64'd0);
        check("rst data_rd", 64'(port_data_rd), 64'd0);
        apply_reset();

        // Simultaneous starts: port 0 then port 1 at 3 cycles per transfer.
        drive_req(0, 1'b0, 32'h100, 32'h0, 4'hF);
        drive_req(1, 1'b0, 32'h200, 32'h0, 4'hF);
        port_start = 2'b11;
        @(negedge wb_clk);
        port_start = '0;
        check("sim both latched", 64'(port_active), 64'd3);
        check("sim cyc not yet", 64'(bus.wb_cyc_o), 64'd0);
        @(negedge wb_clk);
        check("sim first cyc", 64'(bus.wb_cyc_o), 64'd1);
        check("sim first is port0", 64'(bus.wb_adr_o), 64'h100);
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 32'h0A0A_0A0A;
        @(negedge wb_clk);
        bus.wb_ack_i = 1'b0;
        check("sim done port0", 64'(port_done), 64'd1);
        @(negedge wb_clk);
        check("sim port1 still pending", 64'(port_active), 64'd2);
        check("sim cyc low in idle", 64'(bus.wb_cyc_o), 64'd0);
        @(negedge wb_clk);
        check("sim second cyc", 64'(bus.wb_cyc_o), 64'd1);
        check("sim second is port1", 64'(bus.wb_adr_o), 64'h200);
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 32'h0B0B_0B0B;
        @(negedge wb_clk);
        bus.wb_ack_i = 1'b0;
        check("sim done port1", 64'(port_done), 64'd2);
        check("sim data_rd", 64'(port_data_rd), 64'h0B0B_0B0B_0A0A_0A0A);
        @(negedge wb_clk);
        check("sim all idle", 64'(port_active), 64'd0);

        // Repeat: pointer wrapped to 0 after port 1, so port 0 goes first again.
        port_start = 2'b11;
        @(negedge wb_clk);
        port_start = '0;
        serve(32'h0C0C_0C0C, got_adr);
        check("rr repeat first port0", 64'(got_adr), 64'h100);
        serve(32'h0D0D_0D0D, got_adr);
        check("rr repeat second port1", 64'(got_adr), 64'h200);
        check("rr repeat data_rd", 64'(port_data_rd), 64'h0D0D_0D0D_0C0C_0C0C);

        // Table of single transfers starting from a clean reset.
        apply_reset();
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Second start on the active port during BUS is ignored.
        drive_req(1, 1'b0, 32'h300, 32'h0, 4'hF);
        port_start = 2'b10;
        @(negedge wb_clk);
        port_start = '0;
        @(negedge wb_clk);
        check("ign cyc", 64'(bus.wb_cyc_o), 64'd1);
        drive_req(1, 1'b1, 32'h999, 32'h7777_7777, 4'h1);
        port_start = 2'b10;
        @(negedge wb_clk);
        port_start = '0;
        check("ign adr stable", 64'(bus.wb_adr_o), 64'h300);
        check("ign we stable", 64'(bus.wb_we_o), 64'd0);
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = 32'h1111_2222;
        @(negedge wb_clk);
        bus.wb_ack_i = 1'b0;
        check("ign done", 64'(port_done), 64'd2);
        check("ign err", 64'(port_err), 64'd0);
        check("ign rd1", 64'(port_data_rd[DW +: DW]), 64'h1111_2222);
        repeat (3) @(negedge wb_clk);
        check("ign no new request", 64'(port_active), 64'd0);
        check("ign no new cycle", 64'(bus.wb_cyc_o), 64'd0);

        // Reset in the middle of a bus cycle.
        drive_req(0, 1'b0, 32'h60, 32'h0, 4'hF);
        port_start = 2'b01;
        @(negedge wb_clk);
        port_start = '0;
        @(negedge wb_clk);
        check("mid cyc up", 64'(bus.wb_cyc_o), 64'd1);
        #2 wb_rst_n = 1'b0;
        #1;
        check("mid rst cyc", 64'(bus.wb_cyc_o), 64'd0);
        check("mid rst stb", 64'(bus.wb_stb_o), 64'd0);
        check("mid rst active", 64'(port_active), 64'd0);
        check("mid rst done", 64'(port_done), 64'd0);
        @(negedge wb_clk);
        check("mid rst still no done", 64'(port_done), 64'd0);
        wb_rst_n = 1'b1;
        run_vec(v_after_rst, 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
